// File: rtl/sipo_packer.sv
// rtl/sipo_packer.sv - packs sixteen 32-bit show-ahead FIFO words into one 512-bit sink FIFO word
// Partial words are padded and emitted on explicit flush or after an idle timeout.
module sipo_packer #(
    parameter int          TIMEOUT = 1024,
    parameter logic [31:0] PAD     = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rd_empty,
    output logic         rd_en,
    input  logic [31:0]  rd_data,
    input  logic         wr_full,
    output logic         wr_en,
    output logic [511:0] wr_data,
    input  logic         flush,
    output logic         busy,
    output logic [15:0]  flush_cnt
);
    localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);

    logic [511:0] acc;
    logic [511:0] out_reg;
    logic [511:0] padded;
    logic [3:0]   idx;
    logic         out_vld;
    logic         flush_pend;
    logic [IW-1:0] idle;
    logic [IW-1:0] idle_n;
    logic         idx_nz;
    logic         last_lane;
    logic         out_free;
    logic         serve;
    logic         timeout_hit;

    assign idx_nz    = (idx != 4'd0);
    assign last_lane = (idx == 4'd15);
    assign out_free  = ~out_vld | ~wr_full;
    assign rd_en     = ~rd_empty & ~(flush_pend & idx_nz) & (~last_lane | out_free);
    assign serve     = flush_pend & idx_nz & out_free;
    assign wr_en     = out_vld & ~wr_full;
    assign wr_data   = out_reg;
    assign busy      = idx_nz | out_vld | flush_pend;

    // Lanes at or above idx hold stale data from an earlier word, so they are overwritten.
    always_comb begin
        padded = acc;
        for (int k = 0; k < 16; k++) begin
            if (5'(k) >= {1'b0, idx}) begin
                padded[32*k +: 32] = PAD;
            end
        end
    end

    always_comb begin
        idle_n = idle;
        if ((TIMEOUT == 0) || rd_en || serve || !idx_nz) begin
            idle_n = '0;
        end else if (idle != IDLE_MAX) begin
            idle_n = idle + IW'(1);
        end
    end

    // Raising the request on the same edge idle saturates keeps the serve at TIMEOUT+1 cycles.
    assign timeout_hit = (TIMEOUT != 0) && (idle_n == IDLE_MAX) && idx_nz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            out_reg    <= '0;
            idx        <= 4'd0;
            out_vld    <= 1'b0;
            flush_pend <= 1'b0;
            idle       <= '0;
            flush_cnt  <= 16'd0;
        end else begin
            idle <= idle_n;

            if (rd_en) begin
                acc[{idx, 5'b0} +: 32] <= rd_data;
                if (last_lane) begin
                    out_reg <= {rd_data, acc[479:0]};
                    idx     <= 4'd0;
                end else begin
                    idx <= idx + 4'd1;
                end
            end else if (serve) begin
                out_reg <= padded;
                idx     <= 4'd0;
                if (flush_cnt != 16'hFFFF) begin
                    flush_cnt <= flush_cnt + 16'd1;
                end
            end

            if ((rd_en && last_lane) || serve) begin
                out_vld <= 1'b1;
            end else if (wr_en) begin
                out_vld <= 1'b0;
            end

            if (serve) begin
                flush_pend <= 1'b0;
            end else if (flush || timeout_hit) begin
                flush_pend <= 1'b1;
            end else if (!idx_nz) begin
                flush_pend <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sipo_packer.sv
// tb/tb_sipo_packer.sv - directed self-checking bench for sipo_packer
module tb_sipo_packer;
    localparam logic [31:0] PADW = 32'hDEAD_BEEF;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rd_empty;
    logic         rd_en;
    logic [31:0]  rd_data;
    logic         wr_full = 1'b0;
    logic         wr_en;
    logic [511:0] wr_data;
    logic         flush = 1'b0;
    logic         busy;
    logic [15:0]  flush_cnt;

    sipo_packer #(.TIMEOUT(8), .PAD(PADW)) dut (
        .clk(clk), .rst(rst), .rd_empty(rd_empty), .rd_en(rd_en), .rd_data(rd_data),
        .wr_full(wr_full), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
        .busy(busy), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    logic [31:0]  mem [0:255];
    int           src_len = 0;
    int           rd_ptr = 0;
    int           cyc = 0;
    int           n_acc = 0;
    int           n_push = 0;
    int           acc_cyc [0:255];
    int           push_cyc [0:31];
    logic [511:0] push_dat [0:31];
    int           base_acc;
    int           base_push;
    int           n_checks = 0;
    int           n_errors = 0;

    assign rd_empty = (rd_ptr == src_len);
    assign rd_data  = mem[rd_ptr[7:0]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en) begin
            rd_ptr <= rd_ptr + 1;
            acc_cyc[n_acc[7:0]] <= cyc;
            n_acc <= n_acc + 1;
        end
        if (wr_en) begin
            push_cyc[n_push[4:0]] <= cyc;
            push_dat[n_push[4:0]] <= wr_data;
            n_push <= n_push + 1;
        end
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load(input int n, input logic [31:0] base, input logic [31:0] step);
        for (int i = 0; i < n; i++) begin
            mem[src_len[7:0] + 8'(i)] = base + step * i;
        end
        src_len = src_len + n;
    endtask

    function automatic logic [511:0] exp_word(input logic [31:0] base, input logic [31:0] step, input int n);
        logic [511:0] w;
        for (int k = 0; k < 16; k++) begin
            w[32*k +: 32] = (k < n) ? base + step * k : PADW;
        end
        return w;
    endfunction

    task automatic wait_acc(input int k, input int limit);
        int g = 0;
        while ((n_acc - base_acc) < k && g < limit) begin
            @(negedge clk);
            g++;
        end
    endtask

    task automatic wait_push(input int k, input int limit);
        int g = 0;
        while ((n_push - base_push) < k && g < limit) begin
            @(negedge clk);
            g++;
        end
    endtask

    task automatic mark;
        base_acc  = n_acc;
        base_push = n_push;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("reset_wr_en", wr_en, 0);
        check("reset_busy", busy, 0);
        check("reset_flush_cnt", flush_cnt, 0);
        check("reset_rd_en_empty", rd_en, 0);
        rst = 1'b0;
        @(negedge clk);

        // full words, sink always ready
        mark();
        load(32, 0, 4);
        wait_push(2, 60);
        check("full_npush", n_push - base_push, 2);
        check("full_word0", push_dat[base_push], exp_word(0, 4, 16));
        check("full_word1", push_dat[base_push + 1], exp_word(64, 4, 16));
        check("full_push0_lat", push_cyc[base_push] - acc_cyc[base_acc], 16);
        check("full_push1_lat", push_cyc[base_push + 1] - acc_cyc[base_acc], 32);
        check("full_no_gaps", acc_cyc[base_acc + 31] - acc_cyc[base_acc], 31);
        @(negedge clk);

        // backpressure after first word completes
        mark();
        load(32, 100, 1);
        wait_acc(16, 40);
        wr_full = 1'b1;
        wait_acc(31, 40);
        check("bp_acc_lanes", n_acc - base_acc, 31);
        repeat (3) @(negedge clk);
        #1;
        check("bp_rd_en_stall", rd_en, 0);
        check("bp_held", n_push - base_push, 0);
        check("bp_busy", busy, 1);
        wr_full = 1'b0;
        wait_push(2, 20);
        check("bp_npush", n_push - base_push, 2);
        check("bp_word0", push_dat[base_push], exp_word(100, 1, 16));
        check("bp_word1", push_dat[base_push + 1], exp_word(116, 1, 16));
        check("bp_resumed", n_acc - base_acc, 32);
        @(negedge clk);

        // explicit flush of a 5-word partial
        mark();
        load(5, 1, 1);
        wait_acc(5, 20);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_push(1, 20);
        check("flush_npush", n_push - base_push, 1);
        check("flush_word", push_dat[base_push], exp_word(1, 1, 5));
        #1;
        check("flush_cnt1", flush_cnt, 1);
        check("flush_idle", busy, 0);

        // idle timeout flush
        mark();
        load(3, 32'h300, 1);
        wait_acc(3, 20);
        wait_push(1, 40);
        check("to_npush", n_push - base_push, 1);
        check("to_word", push_dat[base_push], exp_word(32'h300, 1, 3));
        check("to_latency_ok", ((push_cyc[base_push] - acc_cyc[base_acc + 2]) >= 9) &&
                               ((push_cyc[base_push] - acc_cyc[base_acc + 2]) <= 10), 1);
        check("to_flush_cnt", flush_cnt, 2);
        mark();
        repeat (30) @(negedge clk);
        check("to_empty_no_push", n_push - base_push, 0);

        // flush with nothing accumulated
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (10) @(negedge clk);
        check("flush0_no_push", n_push - base_push, 0);
        check("flush0_cnt", flush_cnt, 2);

        // flush on the same cycle as the 16th accept
        mark();
        load(16, 32'h500, 1);
        wait_acc(15, 30);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (20) @(negedge clk);
        check("f16_npush", n_push - base_push, 1);
        check("f16_word", push_dat[base_push], exp_word(32'h500, 1, 16));
        check("f16_cnt", flush_cnt, 2);

        // reset in the middle of a word
        mark();
        load(7, 32'h700, 1);
        wait_acc(7, 20);
        rst = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_no_push", n_push - base_push, 0);
        check("rst_flush_cnt", flush_cnt, 0);
        load(1, 32'h900, 1);
        #1;
        check("rst_rd_en_follows", rd_en, 1);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
